exec_unit_mdu: RTL and testbench
================================

// Module: exec_unit_mdu
// PURPOSE
// - Parametrised successor of the single-cycle ALU for the pipelined CPU EX stage.
// - Registered ALU: add/sub/logic/compare/shift ops with one-cycle latency and
//   overflow exceptions. Adds an iterative mult/div unit with HI/LO registers.
// - Adds a valid/ready handshake and a flush input so an exception or interrupt
//   can abort work already in flight.
// PARAMETERS
// - WIDTH      32  operand/result width; must be a power of 2, >= 8
// - MUL_CYCLES 5   busy cycles for MULT/MULTU (>= 1)
// - DIV_CYCLES 10  busy cycles for DIV/DIVU (>= 1)
// PORTS
// - clk        in   1          clock; all state updates on rising edge
// - reset      in   1          synchronous, active-high reset
// - in_valid   in   1          op/operands valid this cycle
// - in_ready   out  1          unit can accept; = !busy
// - op         in   5          operation code (exec_pkg::OP_*)
// - a          in   WIDTH      operand A (rs); shift amount = a[$clog2(WIDTH)-1:0]
// - b          in   WIDTH      operand B (rt/imm); value that is shifted
// - ov_en      in   1          arithmetic overflow check enabled (ADD/SUB)
// - st_ov_en   in   1          address overflow check enabled (ADD only, load/store)
// - flush      in   1          abort: kill pending result and any mult/div
// - out_valid  out  1          result/exception flags valid
// - result     out  WIDTH      registered result
// - exc_ov     out  1          arithmetic overflow, qualified by out_valid
// - exc_st_ov  out  1          address overflow, qualified by out_valid
// - busy       out  1          mult/div in progress
// - hi, lo     out  WIDTH      architectural HI/LO registers
// BEHAVIOUR
// - Reset: out_valid=0, result=0, exc_ov=0, exc_st_ov=0, busy=0, hi=0, lo=0, counter=0.
// - Accept = in_valid & in_ready & !flush. Reset has priority over flush.
//   Flush has priority over accept.
// - ALU ops (ADD 0, SUB 1, OR 2, AND 3, SLT 4, SLTU 5, SLL 6, SRL 7, SRA 8,
//   XOR 9, NOR 10, MFHI 15, MFLO 16):
//   - Latency is 1. out_valid=1 in the cycle after accept. result is modulo 2^WIDTH.
//   - SLT is signed compare; SLTU is unsigned compare. Both give a zero-extended 0/1.
//   - MFHI/MFLO return the hi/lo value at the accept edge.
// - Overflow: detected via WIDTH+1 sign extension, i.e. bit[WIDTH] != bit[WIDTH-1].
//   - exc_ov    = ov_en & ((ADD & add overflow) | (SUB & sub overflow)).
//   - exc_st_ov = st_ov_en & ADD & add overflow.
//   - result is still written when a flag is raised.
// - Ops that write no result (MULT 11, MULTU 12, DIV 13, DIV_U 14, MTHI 17, MTLO 18)
//   and unknown codes: out_valid=1 next cycle with result=0 and both flags 0.
// - MTHI/MTLO: hi/lo <= a at the accept edge. Not blocked by anything, because
//   in_ready=1 whenever they can be accepted.
// - out_valid is a 1-cycle pulse per accept. There is no output back-pressure.
//   The consumer must sample it.
// - Mult/div FSM has states IDLE and BUSY:
//   - IDLE -> BUSY on accept of MULT/MULTU/DIV/DIVU. Operands and op are latched.
//     counter <= MUL_CYCLES or DIV_CYCLES.
//   - BUSY: busy=1 and in_ready=0; counter decrements every cycle.
//   - Leaving BUSY when counter==1: hi/lo are written at that edge, then the FSM
//     goes to IDLE. busy drops in the same cycle that the new hi/lo are visible.
//   - Result placement: MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
//     DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward
//     zero and the remainder takes the sign of the dividend.
//   - Divide by zero: hi/lo are left unchanged; busy still lasts the full DIV_CYCLES.
//   - Signed overflow (MIN / -1): lo = MIN, hi = 0.
//   - The product and quotient may be computed combinationally and applied at
//     completion. A cycle-accurate iterative datapath is not required.
// - flush:
//   - out_valid is 0 the next cycle.
//   - A BUSY op goes to IDLE with hi/lo unchanged.
//   - An op presented in the same cycle as flush is not accepted.
// - reset mid-operation: same as flush, and hi/lo are also cleared.
// STRUCTURE
// - exec_pkg holds:
//   - localparam op codes OP_ADD..OP_MTLO (5-bit)
//   - the mdu_state_t typedef {IDLE, BUSY}
//   - the OP_W=5 constant
// - Sub-module mdu_core: the FSM, counter, latched operands and hi/lo registers.
// - The top level holds the registered ALU datapath, overflow logic and handshake.
// TESTING (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10)
// - ADD a=7FFFFFFF b=1 ov_en=1 -> next cycle out_valid=1, result=80000000, exc_ov=1, exc_st_ov=0.
// - SUB a=80000000 b=1 ov_en=1 -> exc_ov=1. Same with ov_en=0 -> exc_ov=0, result=7FFFFFFF.
// - SLT a=FFFFFFFF b=1 -> result=1. SLTU with the same operands -> 0.
//   SRA b=80000000 a=4 -> result=F8000000.
// - MULT a=FFFFFFFE(-2) b=3 -> busy for 5 cycles, in_ready=0. Then hi=FFFFFFFF, lo=FFFFFFFA.
//   MFLO issued while busy is held off; after busy drops it returns FFFFFFFA.
// - DIV a=FFFFFFF9(-7) b=2 -> after 10 cycles lo=FFFFFFFD, hi=FFFFFFFF.
//   DIVU a=5 b=0 -> hi/lo unchanged.
// - MULTU in progress, flush at cycle 2 -> busy=0 the next cycle, hi/lo keep their old
//   values. ADD+flush in the same cycle -> no out_valid. reset mid-DIV -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared op codes, mult/div FSM state type and helpers for the EX-stage
// execution unit.
package exec_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
  localparam logic [OP_W-1:0] OP_OR    = 5'd2;
  localparam logic [OP_W-1:0] OP_AND   = 5'd3;
  localparam logic [OP_W-1:0] OP_SLT   = 5'd4;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'd5;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd7;
  localparam logic [OP_W-1:0] OP_SRA   = 5'd8;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd9;
  localparam logic [OP_W-1:0] OP_NOR   = 5'd10;
  localparam logic [OP_W-1:0] OP_MULT  = 5'd11;
  localparam logic [OP_W-1:0] OP_MULTU = 5'd12;
  localparam logic [OP_W-1:0] OP_DIV   = 5'd13;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'd14;
  localparam logic [OP_W-1:0] OP_MFHI  = 5'd15;
  localparam logic [OP_W-1:0] OP_MFLO  = 5'd16;
  localparam logic [OP_W-1:0] OP_MTHI  = 5'd17;
  localparam logic [OP_W-1:0] OP_MTLO  = 5'd18;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Mult/div unit: IDLE/BUSY FSM, busy counter, latched operands and the HI/LO
// registers. The arithmetic is combinational and committed on the last busy cycle.
module mdu_core
  import exec_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic             i_wr_hi,
  input  logic             i_wr_lo,
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output mdu_state_t       o_state,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_t         r_state;
  mdu_state_t         w_state_nxt;
  logic               w_done;
  logic [CNT_W-1:0]   r_cnt;
  logic [OP_W-1:0]    r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_div_zero;
  logic               w_div_ovf;
  logic [WIDTH-1:0]   w_divisor;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_quo_u;
  logic [WIDTH-1:0]   w_rem_u;
  logic [2*WIDTH-1:0] w_res;
  logic               w_wr_en;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Flush wins over completion so an aborted op never touches HI/LO.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = BUSY;
      BUSY: begin
        if (i_flush) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // MIN / -1 and x / 0 divide by 1 instead: MIN/1 gives the required lo=MIN, hi=0.
  always_comb begin
    w_div_zero = (r_b == '0);
    w_div_ovf  = (r_op == OP_DIV) && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&r_b);
    w_divisor  = (w_div_zero || w_div_ovf) ? WIDTH'(1) : r_b;
    w_prod_s   = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
    w_prod_u   = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    w_quo_s    = $signed(r_a) / $signed(w_divisor);
    w_rem_s    = $signed(r_a) % $signed(w_divisor);
    w_quo_u    = r_a / w_divisor;
    w_rem_u    = r_a % w_divisor;
    w_res      = '0;
    case (r_op)
      OP_MULT:  w_res = w_prod_s;
      OP_MULTU: w_res = w_prod_u;
      OP_DIV:   w_res = {w_rem_s, w_quo_s};
      OP_DIVU:  w_res = {w_rem_u, w_quo_u};
      default:  w_res = '0;
    endcase
    w_wr_en = !(((r_op == OP_DIV) || (r_op == OP_DIVU)) && w_div_zero);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_cnt <= is_mul(i_op) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
        r_op  <= i_op;
        r_a   <= i_a;
        r_b   <= i_b;
      end else if (r_state == BUSY) begin
        r_cnt <= i_flush ? '0 : r_cnt - CNT_W'(1);
      end
      if (w_done && w_wr_en) begin
        {r_hi, r_lo} <= w_res;
      end else begin
        if (i_wr_hi) r_hi <= i_a;
        if (i_wr_lo) r_lo <= i_a;
      end
    end
  end

  assign o_state = r_state;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule

// File: rtl/exec_unit_mdu.sv
// EX-stage execution unit: registered one-cycle ALU with overflow flags and a
// valid/ready front end feeding the iterative mult/div core.
module exec_unit_mdu
  import exec_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ov_en,
  input  logic             st_ov_en,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             exc_ov,
  output logic             exc_st_ov,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SH_W = $clog2(WIDTH);

  // Handshake: an op transfers on a cycle with in_valid & in_ready & !flush;
  // in_ready depends only on the mult/div state, and out_valid is a one-cycle
  // pulse with no back-pressure.
  mdu_state_t       w_state;
  logic             w_accept;
  logic [WIDTH:0]   w_add_ext;
  logic [WIDTH:0]   w_sub_ext;
  logic             w_add_ov;
  logic             w_sub_ov;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_exc_ov;
  logic             w_exc_st_ov;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_exc_ov;
  logic             r_exc_st_ov;

  assign in_ready = (w_state == IDLE);
  assign busy     = (w_state == BUSY);
  assign w_accept = in_valid & in_ready & ~flush;

  mdu_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept & is_muldiv(op)),
    .i_flush (flush),
    .i_wr_hi (w_accept & (op == OP_MTHI)),
    .i_wr_lo (w_accept & (op == OP_MTLO)),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .o_state (w_state),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  // Overflow: the extra sign bit disagrees with the MSB of the sum.
  always_comb begin
    w_add_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    w_sub_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    w_add_ov  = w_add_ext[WIDTH] ^ w_add_ext[WIDTH-1];
    w_sub_ov  = w_sub_ext[WIDTH] ^ w_sub_ext[WIDTH-1];
    w_shamt   = a[SH_W-1:0];
    w_alu_res = '0;
    case (op)
      OP_ADD:  w_alu_res = w_add_ext[WIDTH-1:0];
      OP_SUB:  w_alu_res = w_sub_ext[WIDTH-1:0];
      OP_OR:   w_alu_res = a | b;
      OP_AND:  w_alu_res = a & b;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  w_alu_res = b << w_shamt;
      OP_SRL:  w_alu_res = b >> w_shamt;
      OP_SRA:  w_alu_res = WIDTH'($signed(b) >>> w_shamt);
      OP_XOR:  w_alu_res = a ^ b;
      OP_NOR:  w_alu_res = ~(a | b);
      OP_MFHI: w_alu_res = hi;
      OP_MFLO: w_alu_res = lo;
      default: w_alu_res = '0;
    endcase
    w_exc_ov    = ov_en & (((op == OP_ADD) & w_add_ov) | ((op == OP_SUB) & w_sub_ov));
    w_exc_st_ov = st_ov_en & (op == OP_ADD) & w_add_ov;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_exc_ov    <= 1'b0;
      r_exc_st_ov <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_result    <= w_alu_res;
        r_exc_ov    <= w_exc_ov;
        r_exc_st_ov <= w_exc_st_ov;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign exc_ov    = r_exc_ov;
  assign exc_st_ov = r_exc_st_ov;

endmodule

// File: tb/tb_exec_unit_mdu.sv
// Self-checking bench for exec_unit_mdu: directed cases with literal
// expectations plus randomized traffic compared each cycle to a behavioural model.
module tb_exec_unit_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ov_en;
  logic        st_ov_en;
  logic        flush;
  logic        out_valid;
  logic [31:0] result;
  logic        exc_ov;
  logic        exc_st_ov;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  exec_unit_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .ov_en     (ov_en),
    .st_ov_en  (st_ov_en),
    .flush     (flush),
    .out_valid (out_valid),
    .result    (result),
    .exc_ov    (exc_ov),
    .exc_st_ov (exc_st_ov),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_en = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_hi, m_lo, m_res;
  logic        m_ov, m_eov, m_est;
  logic [4:0]  p_op;
  logic [31:0] p_a, p_b;
  longint      sa, sb, s, q, r;
  logic [63:0] u64;
  logic        acc, aov;

  task automatic md_finish();
    case (p_op)
      5'd11: begin u64 = 64'(longint'($signed(p_a)) * longint'($signed(p_b))); {m_hi, m_lo} = u64; end
      5'd12: begin u64 = {32'd0, p_a} * {32'd0, p_b}; {m_hi, m_lo} = u64; end
      5'd13: if (p_b != 0) begin
        q = longint'($signed(p_a)) / longint'($signed(p_b));
        r = longint'($signed(p_a)) % longint'($signed(p_b));
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      5'd14: if (p_b != 0) begin m_lo = p_a / p_b; m_hi = p_a % p_b; end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_en = 1'b1; m_cnt = 0; m_hi = 0; m_lo = 0;
      m_ov = 0; m_res = 0; m_eov = 0; m_est = 0;
    end else begin
      acc = in_valid && (m_cnt == 0) && !flush;
      if (m_cnt > 0) begin
        if (flush) m_cnt = 0;
        else if (m_cnt == 1) begin md_finish(); m_cnt = 0; end
        else m_cnt--;
      end
      m_ov = acc;
      if (acc) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m_res = 0; m_eov = 0; m_est = 0;
        case (op)
          5'd0: begin
            s = sa + sb; m_res = s[31:0];
            aov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            m_eov = ov_en & aov; m_est = st_ov_en & aov;
          end
          5'd1: begin
            s = sa - sb; m_res = s[31:0];
            m_eov = ov_en & ((s > 64'sd2147483647) || (s < -64'sd2147483648));
          end
          5'd2:  m_res = a | b;
          5'd3:  m_res = a & b;
          5'd4:  m_res = (sa < sb) ? 32'd1 : 32'd0;
          5'd5:  m_res = (a < b) ? 32'd1 : 32'd0;
          5'd6:  m_res = b << a[4:0];
          5'd7:  m_res = b >> a[4:0];
          5'd8:  begin s = sb >>> a[4:0]; m_res = s[31:0]; end
          5'd9:  m_res = a ^ b;
          5'd10: m_res = ~(a | b);
          5'd11, 5'd12, 5'd13, 5'd14: begin
            p_op = op; p_a = a; p_b = b;
            m_cnt = (op <= 5'd12) ? 5 : 10;
          end
          5'd15: m_res = m_hi;
          5'd16: m_res = m_lo;
          5'd17: m_hi = a;
          5'd18: m_lo = a;
          default: ;
        endcase
      end
    end
  end

  // Single compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      chk("in_ready", 64'(in_ready), 64'(m_cnt == 0));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      if (m_ov) begin
        chk("result", 64'(result), 64'(m_res));
        chk("exc_ov", 64'(exc_ov), 64'(m_eov));
        chk("exc_st_ov", 64'(exc_st_ov), 64'(m_est));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [4:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                       input logic t_ov, input logic t_st);
    in_valid = 1'b1; op = t_op; a = t_a; b = t_b; ov_en = t_ov; st_ov_en = t_st; flush = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    chk("wait_idle", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int n;
  int sel;

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0;
    a = '0; b = '0; ov_en = 1'b0; st_ov_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(5'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_res", 64'(result), 64'h8000_0000);
    chk("add_ov", 64'(exc_ov), 64'd1);
    chk("add_st_ov", 64'(exc_st_ov), 64'd0);
    issue(5'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    chk("add_st_ov2", 64'(exc_st_ov), 64'd1);
    chk("add_ov2", 64'(exc_ov), 64'd0);
    issue(5'd1, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
    chk("sub_ov", 64'(exc_ov), 64'd1);
    issue(5'd1, 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    chk("sub_ov_off", 64'(exc_ov), 64'd0);
    chk("sub_res", 64'(result), 64'h7FFF_FFFF);
    issue(5'd4, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("slt", 64'(result), 64'd1);
    issue(5'd5, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("sltu", 64'(result), 64'd0);
    issue(5'd8, 32'h4, 32'h8000_0000, 1'b0, 1'b0);
    chk("sra", 64'(result), 64'hF800_0000);

    issue(5'd11, 32'hFFFF_FFFE, 32'h3, 1'b0, 1'b0);
    chk("mult_busy", 64'(busy), 64'd1);
    chk("mult_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; op = 5'd16;
    n = 0;
    while (!in_ready && n < 20) begin n++; @(negedge clk); end
    chk("mult_cycles", 64'(n), 64'd5);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mflo_valid", 64'(out_valid), 64'd1);
    chk("mflo_res", 64'(result), 64'hFFFF_FFFA);

    issue(5'd13, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0);
    wait_idle(n);
    chk("div_cycles", 64'(n), 64'd10);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    issue(5'd14, 32'h5, 32'h0, 1'b0, 1'b0);
    wait_idle(n);
    chk("divz_cycles", 64'(n), 64'd10);
    chk("divz_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("divz_hi", 64'(hi), 64'hFFFF_FFFF);
    issue(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle(n);
    chk("divovf_lo", 64'(lo), 64'h8000_0000);
    chk("divovf_hi", 64'(hi), 64'h0);

    issue(5'd17, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    issue(5'd18, 32'h9ABC_DEF0, 32'h0, 1'b0, 1'b0);
    chk("mthi", 64'(hi), 64'h1234_5678);
    chk("mtlo", 64'(lo), 64'h9ABC_DEF0);
    issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'h1234_5678);
    chk("flush_lo", 64'(lo), 64'h9ABC_DEF0);
    in_valid = 1'b1; op = 5'd0; a = 32'h1; b = 32'h2; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_add_valid", 64'(out_valid), 64'd0);
    issue(5'd13, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstdiv_hi", 64'(hi), 64'd0);
    chk("rstdiv_lo", 64'(lo), 64'd0);
    chk("rstdiv_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel <= 5)      op = 5'($urandom_range(0, 10));
      else if (sel == 6) op = 5'($urandom_range(15, 18));
      else if (sel == 7) op = 5'($urandom_range(11, 14));
      else if (sel == 8) op = 5'($urandom_range(19, 31));
      else               op = 5'($urandom_range(0, 1));
      a = rnd_val();
      b = rnd_val();
      ov_en = 1'($urandom_range(0, 1));
      st_ov_en = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
    wait_idle(n);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
